vga_scaled_display: RTL

VGA_SCALED_DISPLAY -- requirements
Module: vga_scaled_display

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_timing_gen.sv | 58 +++++
 rtl/vga_scaled_display.sv | 123 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, per-pixel control flags
// and the RGB332 to RGB444 pin expansion.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Control bits that must stay aligned with the pixel they describe.
    // Sync bits here mean "asserted", independent of pin polarity.
    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
        logic frame_first;
    } vga_flags_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // MSB replication so full-scale 3/2-bit values map to full-scale 4-bit.
    function automatic rgb444_t expand_rgb332(input logic [7:0] c);
        rgb444_t o;
        o.r = {c[7:5], c[7]};
        o.g = {c[4:2], c[4]};
        o.b = {c[1:0], c[1:0]};
        return o;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with undelayed visible, sync and
// frame-start decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
    parameter int VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
) (
    input  logic            vga_clk,
    input  logic            rst,
    output logic [HC_W-1:0] hc,
    output logic [VC_W-1:0] vc,
    output vga_flags_t      flags
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter widths hold H_TOTAL/V_TOTAL themselves, so every bound below
    // fits without wrapping.
    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0] H_VIS    = HC_W'(H_ACTIVE);
    localparam logic [VC_W-1:0] V_VIS    = VC_W'(V_ACTIVE);
    localparam logic [HC_W-1:0] HS_START = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] VS_START = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    always_comb begin
        flags             = '0;
        flags.visible     = (hc < H_VIS) && (vc < V_VIS);
        flags.hsync       = (hc >= HS_START) && (hc < HS_END);
        flags.vsync       = (vc >= VS_START) && (vc < VS_END);
        flags.frame_first = (hc == '0) && (vc == '0);
    end

endmodule

// File: rtl/vga_scaled_display.sv
// Scaled VGA output: exposes tile coordinates to an external colour source of
// fixed latency and realigns sync/visible flags with the returned colour.
module vga_scaled_display
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter int SCALE_SHIFT = 3,
    parameter int PIX_LAT     = 1,
    parameter int SYNC_POL    = 0,
    localparam int TX_RAW     = $clog2(H_ACTIVE >> SCALE_SHIFT),
    localparam int TY_RAW     = $clog2(V_ACTIVE >> SCALE_SHIFT),
    localparam int TX_W       = (TX_RAW < 1) ? 1 : TX_RAW,
    localparam int TY_W       = (TY_RAW < 1) ? 1 : TY_RAW
) (
    input  logic            vga_clk,
    input  logic            rst,
    output logic [TX_W-1:0] tile_x,
    output logic [TY_W-1:0] tile_y,
    input  logic [7:0]      color_in,
    output logic            hsync,
    output logic            vsync,
    output logic [3:0]      red,
    output logic [3:0]      green,
    output logic [3:0]      blue,
    output logic            active,
    output logic            frame_start
);

    localparam int   HC_W     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1);
    localparam int   VC_W     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1);
    localparam logic SYNC_ACT = (SYNC_POL != 0);

    if ((SCALE_SHIFT < 0) || (SCALE_SHIFT > 4)) begin : g_bad_scale
        $fatal(1, "vga_scaled_display: SCALE_SHIFT must be 0..4");
    end
    if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_h
        $fatal(1, "vga_scaled_display: H_ACTIVE not divisible by tile size");
    end
    if ((V_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_v
        $fatal(1, "vga_scaled_display: V_ACTIVE not divisible by tile size");
    end
    if ((PIX_LAT < 0) || (PIX_LAT > 4)) begin : g_bad_lat
        $fatal(1, "vga_scaled_display: PIX_LAT must be 0..4");
    end

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    vga_flags_t      flags_p0;
    vga_flags_t      flags_dly;
    rgb444_t         pix_rgb;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HC_W     (HC_W),
        .VC_W     (VC_W)
    ) u_timing (
        .vga_clk (vga_clk),
        .rst     (rst),
        .hc      (hc),
        .vc      (vc),
        .flags   (flags_p0)
    );

    // Stage p0: tile request to the colour source, straight from the counters.
    assign tile_x = flags_p0.visible ? TX_W'(hc >> SCALE_SHIFT) : '0;
    assign tile_y = flags_p0.visible ? TY_W'(vc >> SCALE_SHIFT) : '0;

    // Stages p1..pPIX_LAT: flags wait for the colour source to answer.
    if (PIX_LAT == 0) begin : g_no_dly
        assign flags_dly = flags_p0;
    end else begin : g_dly
        vga_flags_t flags_pipe [PIX_LAT];

        always_ff @(posedge vga_clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < PIX_LAT; i++) flags_pipe[i] <= '0;
            end else begin
                flags_pipe[0] <= flags_p0;
                for (int i = 1; i < PIX_LAT; i++) flags_pipe[i] <= flags_pipe[i-1];
            end
        end

        assign flags_dly = flags_pipe[PIX_LAT-1];
    end

    assign pix_rgb = expand_rgb332(color_in);

    // Output stage: colour and its flags are captured on the same edge.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            active      <= 1'b0;
            frame_start <= 1'b0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
        end else begin
            hsync       <= flags_dly.hsync ? SYNC_ACT : ~SYNC_ACT;
            vsync       <= flags_dly.vsync ? SYNC_ACT : ~SYNC_ACT;
            active      <= flags_dly.visible;
            frame_start <= flags_dly.frame_first;
            red         <= flags_dly.visible ? pix_rgb.r : '0;
            green       <= flags_dly.visible ? pix_rgb.g : '0;
            blue        <= flags_dly.visible ? pix_rgb.b : '0;
        end
    end

endmodule
